mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store bus access controller with lane steering and load extension.
// Optional REQ-phase bus timeout is compiled in when MEM_ACCESS_TIMEOUT_EN is defined.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  memDataSize,
    input  logic        memBitExt,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        alignErr,
    output logic        timeoutErr,
    output logic        busReq,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [31:0] busWdata,
    output logic [3:0]  busBe,
    input  logic        busAck,
    input  logic [31:0] busRdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    state_t      state_r;
    state_t      nextState_s;
    logic        stall_s;
    logic        accept_s;
    logic        misalignReq_s;
    logic        timeout_s;
    logic        reqValid_s;
    logic        misaligned_s;

    logic [1:0]  size_r;
    logic [1:0]  offset_r;
    logic        ext_r;
    logic [31:0] rdata_r;
    logic        alignErr_r;
    logic        timeoutErr_r;
    logic        busReq_r;
    logic        busWe_r;
    logic [31:0] busAddr_r;
    logic [31:0] busWdata_r;
    logic [3:0]  busBe_r;

    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_HALF: isMisaligned = off[0];
            SZ_BYTE: isMisaligned = 1'b0;
            default: isMisaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] storeBe(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: storeBe = 4'b0001 << off;
            SZ_HALF: storeBe = off[1] ? 4'b1100 : 4'b0011;
            default: storeBe = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] storeData(input logic [31:0] wd, input logic [1:0] size);
        case (size)
            SZ_BYTE: storeData = {4{wd[7:0]}};
            SZ_HALF: storeData = {2{wd[15:0]}};
            default: storeData = wd;
        endcase
    endfunction

    // Picks the addressed lane and sign- or zero-extends it (zeroExt=1 means zero).
    function automatic logic [31:0] extractLoad(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic zeroExt);
        logic [7:0]  laneByte;
        logic [15:0] laneHalf;
        laneByte = word[{off, 3'b000} +: 8];
        laneHalf = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: extractLoad = {{24{~zeroExt & laneByte[7]}}, laneByte};
            SZ_HALF: extractLoad = {{16{~zeroExt & laneHalf[15]}}, laneHalf};
            default: extractLoad = word;
        endcase
    endfunction

    assign reqValid_s   = memRead | memWrite;
    assign misaligned_s = isMisaligned(memDataSize, addr[1:0]);

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] reqCnt_r;

    // busAck on the expiry edge takes precedence over the timeout.
    assign timeout_s = (state_r == REQ) && !busAck && (reqCnt_r == CNT_W'(TIMEOUT_CYC - 1));

    // Counts cycles spent in REQ, restarting on every accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reqCnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            reqCnt_r <= {CNT_W{1'b0}};
        end else if (state_r == REQ) begin
            reqCnt_r <= reqCnt_r + CNT_W'(1);
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state, stall and request classification.
    always_comb begin
        nextState_s   = state_r;
        stall_s       = 1'b0;
        accept_s      = 1'b0;
        misalignReq_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (reqValid_s && !misaligned_s) begin
                    accept_s    = 1'b1;
                    stall_s     = 1'b1;
                    nextState_s = REQ;
                end else if (reqValid_s) begin
                    misalignReq_s = 1'b1;
                    nextState_s   = IDLE;
                end else begin
                    nextState_s = IDLE;
                end
            end
            REQ: begin
                stall_s = 1'b1;
                if (busAck || timeout_s) begin
                    nextState_s = DONE;
                end else begin
                    nextState_s = REQ;
                end
            end
            DONE: begin
                nextState_s = IDLE;
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // Bus-side registers, load result capture and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_r       <= 2'b00;
            offset_r     <= 2'b00;
            ext_r        <= 1'b0;
            rdata_r      <= 32'h0000_0000;
            alignErr_r   <= 1'b0;
            timeoutErr_r <= 1'b0;
            busReq_r     <= 1'b0;
            busWe_r      <= 1'b0;
            busAddr_r    <= 32'h0000_0000;
            busWdata_r   <= 32'h0000_0000;
            busBe_r      <= 4'b0000;
        end else begin
            alignErr_r   <= misalignReq_s;
            timeoutErr_r <= timeout_s;
            if (accept_s) begin
                busReq_r   <= 1'b1;
                busWe_r    <= memWrite;
                busAddr_r  <= {addr[31:2], 2'b00};
                busBe_r    <= memWrite ? storeBe(memDataSize, addr[1:0]) : 4'b1111;
                busWdata_r <= memWrite ? storeData(wdata, memDataSize) : 32'h0000_0000;
                size_r     <= memDataSize;
                offset_r   <= addr[1:0];
                ext_r      <= memBitExt;
            end else if ((state_r == REQ) && (busAck || timeout_s)) begin
                busReq_r <= 1'b0;
                // Stores leave the last load result untouched.
                if (!busWe_r) begin
                    rdata_r <= busAck ? extractLoad(busRdata, size_r, offset_r, ext_r)
                                      : 32'h0000_0000;
                end
            end
        end
    end

    assign stall      = stall_s;
    assign rdata      = rdata_r;
    assign alignErr   = alignErr_r;
    assign timeoutErr = timeoutErr_r;
    assign busReq     = busReq_r;
    assign busWe      = busWe_r;
    assign busAddr    = busAddr_r;
    assign busWdata   = busWdata_r;
    assign busBe      = busBe_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, randomized accesses
// against a byte-lane reference model, and reset/timeout corner sequences.
module tb_mem_access_ctrl;

    localparam int TOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memRead, memWrite, memBitExt, busAck;
    logic [1:0]  memDataSize;
    logic [31:0] addr, wdata, busRdata;
    logic [31:0] rdata, busAddr, busWdata;
    logic        stall, alignErr, timeoutErr, busReq, busWe;
    logic [3:0]  busBe;

    int checks = 0;
    int failures = 0;
    logic [31:0] mRdata;

    typedef struct {
        int          stallCyc;
        int          reqCyc;
        int          alignCnt;
        int          toCnt;
        int          unstable;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } obs_t;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        ext;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] brd;
        int          dly;
        int          eStall;
        int          eReq;
        int          eAlign;
        logic        eWe;
        logic [3:0]  eBe;
        logic [31:0] eAddr;
        logic [31:0] eWdata;
        logic [31:0] eRdata;
    } vec_t;

    vec_t vecs[12];

    mem_access_ctrl #(.TIMEOUT_CYC(TOUT)) dut (
        .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
        .memDataSize(memDataSize), .memBitExt(memBitExt), .addr(addr), .wdata(wdata),
        .rdata(rdata), .stall(stall), .alignErr(alignErr), .timeoutErr(timeoutErr),
        .busReq(busReq), .busWe(busWe), .busAddr(busAddr), .busWdata(busWdata),
        .busBe(busBe), .busAck(busAck), .busRdata(busRdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Issue one request for a single cycle, then watch nCyc cycles; ack after dly wait cycles
    // (dly<0 means never ack).
    task automatic runAccess(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic ext, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] brd, input int dly, input int nCyc,
                             output obs_t o);
        o = '{default: 0};
        @(posedge clk); #1;
        memRead = rd; memWrite = wr; memDataSize = sz; memBitExt = ext;
        addr = a; wdata = wd; busAck = 1'b0;
        @(negedge clk);
        if (stall) o.stallCyc++;
        @(posedge clk); #1;
        memRead = 1'b0; memWrite = 1'b0; addr = $urandom(); wdata = $urandom();
        for (int c = 0; c < nCyc; c++) begin
            @(negedge clk);
            if (stall) o.stallCyc++;
            if (alignErr) o.alignCnt++;
            if (timeoutErr) o.toCnt++;
            busAck = 1'b0;
            if (busReq) begin
                o.reqCyc++;
                if (o.reqCyc == 1) begin
                    o.we = busWe; o.be = busBe; o.addr = busAddr; o.wdata = busWdata;
                end else if (busWe !== o.we || busBe !== o.be || busAddr !== o.addr ||
                             busWdata !== o.wdata) begin
                    o.unstable++;
                end
                if (dly >= 0 && o.reqCyc == dly + 1) begin
                    busAck = 1'b1;
                    busRdata = brd;
                end
            end
            if (!busAck) busRdata = $urandom();
        end
        o.rdata = rdata;
    endtask

    // Reference behaviour from the access rules: lanes, byte enables, extension, timing.
    function automatic void model(input logic rd, input logic wr, input logic [1:0] sz,
                                  input logic ext, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] brd, input int dly, output obs_t e);
        int nBytes, off;
        logic timedOut;
        logic [63:0] mask, lane, v, rep;
        e = '{default: 0};
        nBytes = (sz == 2'd2) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(a % 4);
        mask = (64'd1 << (8 * nBytes)) - 64'd1;
`ifdef MEM_ACCESS_TIMEOUT_EN
        timedOut = (dly < 0) || (dly + 1 > TOUT);
`else
        timedOut = 1'b0;
`endif
        if (rd || wr) begin
            if (off % nBytes != 0) begin
                e.alignCnt = 1;
            end else begin
                e.reqCyc = timedOut ? TOUT : dly + 1;
                e.toCnt = timedOut ? 1 : 0;
                e.stallCyc = e.reqCyc + 1;
                e.we = wr;
                e.addr = a - off;
                e.be = wr ? 4'(((1 << nBytes) - 1) << off) : 4'hF;
                rep = 64'd0;
                for (int i = 0; i < 4 / nBytes; i++) rep |= ({32'd0, wd} & mask) << (8 * nBytes * i);
                e.wdata = rep[31:0];
                if (!wr) begin
                    lane = {32'd0, brd} >> (8 * off);
                    v = lane & mask;
                    if (!ext && nBytes < 4 && v[8 * nBytes - 1]) v = v | ~mask;
                    mRdata = timedOut ? 32'd0 : v[31:0];
                end
            end
        end
        e.rdata = mRdata;
    endfunction

    task automatic compareObs(input string tag, input obs_t o, input obs_t e);
        chk({tag, ".stallCycles"}, o.stallCyc, e.stallCyc);
        chk({tag, ".busReqCycles"}, o.reqCyc, e.reqCyc);
        chk({tag, ".alignErrPulses"}, o.alignCnt, e.alignCnt);
        chk({tag, ".timeoutErrPulses"}, o.toCnt, e.toCnt);
        chk({tag, ".busUnstable"}, o.unstable, 0);
        chk({tag, ".rdata"}, o.rdata, e.rdata);
        if (e.reqCyc > 0) begin
            chk({tag, ".busWe"}, o.we, e.we);
            chk({tag, ".busBe"}, o.be, e.be);
            chk({tag, ".busAddr"}, o.addr, e.addr);
            if (e.we) chk({tag, ".busWdata"}, o.wdata, e.wdata);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        obs_t o, e;
        logic rd, wr, ext;
        logic [1:0] sz;
        logic [31:0] a, wd, brd;
        int dly;

        //           name   rd    wr    sz     ext   addr          wdata         busRdata     dly stall req align we  be       busAddr       busWdata      rdata
        vecs[0]  = '{"LB",  1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 2, 1, 0, 1'b0, 4'hF, 32'h0000_0100, 32'h0,        32'hFFFF_FF80};
        vecs[1]  = '{"LHU", 1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0,        32'h8001_0000, 3, 5, 4, 0, 1'b0, 4'hF, 32'h0000_0100, 32'h0,        32'h0000_8001};
        vecs[2]  = '{"SB",  1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0201, 32'h0000_00AB, 32'h1111_1111, 0, 2, 1, 0, 1'b1, 4'h2, 32'h0000_0200, 32'hABAB_ABAB, 32'h0000_8001};
        vecs[3]  = '{"LWmis", 1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0102, 32'h0,      32'h2222_2222, 0, 0, 0, 1, 1'b0, 4'h0, 32'h0,         32'h0,        32'h0000_8001};
        vecs[4]  = '{"LH",  1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0300, 32'h0,        32'h1234_F00D, 1, 3, 2, 0, 1'b0, 4'hF, 32'h0000_0300, 32'h0,        32'hFFFF_F00D};
        vecs[5]  = '{"SH",  1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0302, 32'hDEAD_BEEF, 32'h3333_3333, 2, 4, 3, 0, 1'b1, 4'hC, 32'h0000_0300, 32'hBEEF_BEEF, 32'hFFFF_F00D};
        vecs[6]  = '{"RW",  1'b1, 1'b1, 2'd0, 1'b0, 32'h0000_0404, 32'h1234_5678, 32'h4444_4444, 0, 2, 1, 0, 1'b1, 4'hF, 32'h0000_0404, 32'h1234_5678, 32'hFFFF_F00D};
        vecs[7]  = '{"LBU", 1'b1, 1'b0, 2'd2, 1'b1, 32'h0000_0001, 32'h0,        32'h0000_9A00, 2, 4, 3, 0, 1'b0, 4'hF, 32'h0000_0000, 32'h0,        32'h0000_009A};
        vecs[8]  = '{"LW11", 1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0,       32'hCAFE_BABE, 0, 2, 1, 0, 1'b0, 4'hF, 32'h0000_0010, 32'h0,        32'hCAFE_BABE};
        vecs[9]  = '{"SHmis", 1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0003, 32'h1,      32'h0,         0, 0, 0, 1, 1'b0, 4'h0, 32'h0,         32'h0,        32'hCAFE_BABE};
        vecs[10] = '{"LBpos", 1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0,      32'h007F_0000, 1, 3, 2, 0, 1'b0, 4'hF, 32'h0000_0000, 32'h0,        32'h0000_007F};
        vecs[11] = '{"SB3", 1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0007, 32'h0000_01C3, 32'h0,       0, 2, 1, 0, 1'b1, 4'h8, 32'h0000_0004, 32'hC3C3_C3C3, 32'h0000_007F};

        rst_n = 1'b0; memRead = 1'b0; memWrite = 1'b0; memDataSize = 2'd0; memBitExt = 1'b0;
        addr = 32'h0; wdata = 32'h0; busAck = 1'b0; busRdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst.rdata", rdata, 32'h0);
        chk("rst.busReq", busReq, 32'h0);
        chk("rst.busWe", busWe, 32'h0);
        chk("rst.busAddr", busAddr, 32'h0);
        chk("rst.busWdata", busWdata, 32'h0);
        chk("rst.busBe", busBe, 32'h0);
        chk("rst.alignErr", alignErr, 32'h0);
        chk("rst.timeoutErr", timeoutErr, 32'h0);
        chk("rst.stall", stall, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            runAccess(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].ext, vecs[i].a, vecs[i].wd,
                      vecs[i].brd, vecs[i].dly, vecs[i].dly + 4, o);
            e = '{default: 0};
            e.stallCyc = vecs[i].eStall; e.reqCyc = vecs[i].eReq; e.alignCnt = vecs[i].eAlign;
            e.we = vecs[i].eWe; e.be = vecs[i].eBe; e.addr = vecs[i].eAddr;
            e.wdata = vecs[i].eWdata; e.rdata = vecs[i].eRdata;
            compareObs(vecs[i].name, o, e);
        end
        mRdata = 32'h0000_007F;

        // Acks while idle must neither start a transfer nor touch rdata.
        @(negedge clk); busAck = 1'b1; busRdata = 32'hDEAD_DEAD;
        repeat (3) @(negedge clk);
        chk("idleAck.busReq", busReq, 32'h0);
        chk("idleAck.rdata", rdata, mRdata);
        busAck = 1'b0;

        for (int n = 0; n < 200; n++) begin
            rd = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3)); ext = 1'($urandom_range(0, 1));
            a = $urandom(); wd = $urandom(); brd = $urandom();
            dly = $urandom_range(0, 4);
            model(rd, wr, sz, ext, a, wd, brd, dly, e);
            runAccess(rd, wr, sz, ext, a, wd, brd, dly, dly + 4, o);
            compareObs($sformatf("rand%0d", n), o, e);
        end

`ifdef MEM_ACCESS_TIMEOUT_EN
        model(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0800, 32'h0, 32'h5555_5555, -1, e);
        runAccess(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0800, 32'h0, 32'h5555_5555, -1, TOUT + 6, o);
        compareObs("timeout", o, e);
`else
        model(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0800, 32'h0, 32'h5555_5555, 30, e);
        runAccess(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0800, 32'h0, 32'h5555_5555, 30, 34, o);
        compareObs("longWait", o, e);
`endif
        model(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0900, 32'h0, 32'h6666_7777, TOUT - 1, e);
        runAccess(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0900, 32'h0, 32'h6666_7777, TOUT - 1, TOUT + 4, o);
        compareObs("ackAtExpiry", o, e);

        // Reset in the second REQ cycle, then a request waiting as reset releases.
        @(posedge clk); #1;
        memRead = 1'b1; memDataSize = 2'd0; addr = 32'h0000_0500;
        @(posedge clk); #1;
        memRead = 1'b0;
        @(posedge clk); #1;
        chk("rstReq.busReqBefore", busReq, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstReq.busReq", busReq, 32'h0);
        chk("rstReq.stall", stall, 32'h0);
        chk("rstReq.busAddr", busAddr, 32'h0);
        chk("rstReq.rdata", rdata, 32'h0);
        @(negedge clk);
        memRead = 1'b1; memDataSize = 2'd0; addr = 32'h0000_0600;
        rst_n = 1'b1;
        @(negedge clk);
        chk("postRst.busReq", busReq, 32'h1);
        chk("postRst.busAddr", busAddr, 32'h0000_0600);
        chk("postRst.stall", stall, 32'h1);
        memRead = 1'b0; busAck = 1'b1; busRdata = 32'h1357_9BDF;
        @(negedge clk);
        busAck = 1'b0;
        chk("postRst.doneBusReq", busReq, 32'h0);
        chk("postRst.doneStall", stall, 32'h0);
        chk("postRst.rdata", rdata, 32'h1357_9BDF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
